// File: rtl/o_ddr_fifo_tx.sv
// Small TX FIFO feeding a 2:1 DDR output pin with burst framing.
// Ports: clk/reset/enable/data/valid/last in; ready/DDR pin/active/underrun out.
module o_ddr_fifo_tx #(
  parameter int          DEPTH        = 4,
  parameter int          START_THRESH = 2,
  parameter logic [1:0]  IDLE_PAT     = 2'b00
) (
  input  logic       clk_i_buf,
  input  logic       reset_n_buf,
  input  logic       enable_buf,
  input  logic [1:0] data_i_buf,
  input  logic       valid_i_buf,
  input  logic       last_i_buf,
  output logic       ready_o_buf,
  output logic       data_o_buf,
  output logic       active_o_buf,
  output logic       underrun_o_buf
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = AW + 1;

  typedef enum logic {
    IDLE,
    SEND
  } state_e;

  // Pad buffers (I_BUF, CLK_BUF, O_BUF) are pass-through here.
  logic       clk;
  logic       rst_n;
  logic       en;
  logic       vld;
  logic       lst;
  logic [1:0] din;

  assign clk   = clk_i_buf;
  assign rst_n = reset_n_buf;
  assign en    = enable_buf;
  assign vld   = valid_i_buf;
  assign lst   = last_i_buf;
  assign din   = data_i_buf;

  // FIFO storage: {last, d[1:0]}
  logic [2:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [LW-1:0] level_q;
  logic [LW-1:0] level_d;
  logic [LW-1:0] lastcnt_q;
  logic [LW-1:0] lastcnt_d;

  state_e        state_q;
  logic [1:0]    out_q;
  logic          und_q;
  logic          active_q;

  logic          full;
  logic          push;
  logic          pop;
  logic [2:0]    head;
  logic          start_go;

  assign full  = (level_q == LW'(DEPTH));
  assign push  = vld && !full;
  assign head  = mem_q[rd_ptr_q];
  assign pop   = en && (state_q == SEND)
              && (level_q != '0);

  // Level and count of stored last-flags.
  always_comb begin
    level_d   = level_q;
    lastcnt_d = lastcnt_q;
    if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (!push && pop) begin
      level_d = level_q - LW'(1);
    end
    if (push && lst) begin
      lastcnt_d = lastcnt_d + LW'(1);
    end
    if (pop && head[2]) begin
      lastcnt_d = lastcnt_d - LW'(1);
    end
  end

  // Start decision looks at contents including this
  // cycle's push, so a threshold push starts SEND at once.
  assign start_go =
    (level_d >= LW'(START_THRESH))
    || (lastcnt_d != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {lst, din};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      lastcnt_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      level_q   <= level_d;
      lastcnt_q <= lastcnt_d;
    end
  end

  // Burst FSM; everything holds while enable is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      out_q    <= IDLE_PAT;
      und_q    <= 1'b0;
      active_q <= 1'b0;
    end else if (en) begin
      unique case (state_q)
        IDLE: begin
          out_q <= IDLE_PAT;
          if (start_go) begin
            state_q  <= SEND;
            active_q <= 1'b1;
          end
        end
        SEND: begin
          if (level_q == '0) begin
            und_q    <= 1'b1;
            out_q    <= IDLE_PAT;
            state_q  <= IDLE;
            active_q <= 1'b0;
          end else begin
            out_q <= head[1:0];
            if (head[2]) begin
              state_q  <= IDLE;
              active_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q  <= IDLE;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  // O_DDR: word captured on posedge when E is high.
  // Pin = p ^ n: after posedge shows D[0], after the
  // following negedge shows D[1]. With E low the held
  // word keeps being replayed.
  logic h0_q;
  logic h1_q;
  logic p_q;
  logic n_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h0_q <= 1'b0;
      h1_q <= 1'b0;
      p_q  <= 1'b0;
    end else if (en) begin
      h0_q <= out_q[0];
      h1_q <= out_q[1];
      p_q  <= out_q[0] ^ n_q;
    end else begin
      p_q  <= h0_q ^ n_q;
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q <= 1'b0;
    end else begin
      n_q <= h1_q ^ p_q;
    end
  end

  assign data_o_buf     = p_q ^ n_q;
  assign ready_o_buf    = !full;
  assign active_o_buf   = active_q;
  assign underrun_o_buf = und_q;

endmodule

// File: tb/tb_o_ddr_fifo_tx.sv
// Scoreboard bench for o_ddr_fifo_tx with a queue-based
// reference model of the burst/FIFO/DDR behaviour.
module tb_o_ddr_fifo_tx;

  localparam int         DEPTH = 4;
  localparam int         TH    = 2;
  localparam logic [1:0] IPAT  = 2'b10;

  logic       clk;
  logic       reset_n;
  logic       enable;
  logic [1:0] data;
  logic       valid;
  logic       last;
  logic       ready_o;
  logic       pin_o;
  logic       active_o;
  logic       und_o;

  o_ddr_fifo_tx #(
    .DEPTH       (DEPTH),
    .START_THRESH(TH),
    .IDLE_PAT    (IPAT)
  ) dut (
    .clk_i_buf     (clk),
    .reset_n_buf   (reset_n),
    .enable_buf    (enable),
    .data_i_buf    (data),
    .valid_i_buf   (valid),
    .last_i_buf    (last),
    .ready_o_buf   (ready_o),
    .data_o_buf    (pin_o),
    .active_o_buf  (active_o),
    .underrun_o_buf(und_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] pin;
    logic       act;
    logic       und;
    logic       rdy;
  } exp_t;

  exp_t       sb[$];
  logic [2:0] q[$];
  bit         send_m;
  bit         und_m;
  logic [1:0] outw;
  logic [1:0] pinw;
  bit         chk_en;
  int         checks;
  int         errors;

  task automatic chk(input string nm,
                     input logic [1:0] act,
                     input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic bit has_last();
    foreach (q[i]) if (q[i][2]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    q.delete();
    sb.delete();
    send_m = 1'b0;
    und_m  = 1'b0;
    outw   = IPAT;
    pinw   = 2'b00;
  endtask

  // One clock of stimulus plus the model's view of
  // the following posedge.
  task automatic step(input bit e, input bit v,
                      input bit [1:0] d, input bit l);
    bit psh;
    logic [2:0] w;
    @(negedge clk);
    enable = e;
    valid  = v;
    data   = d;
    last   = l;
    psh = v && ready_o;
    if (e) begin
      pinw = outw;
      if (!send_m) begin
        outw = IPAT;
        if (psh) q.push_back({l, d});
        if (q.size() >= TH || has_last()) send_m = 1'b1;
      end else begin
        if (q.size() == 0) begin
          und_m  = 1'b1;
          outw   = IPAT;
          send_m = 1'b0;
        end else begin
          w = q.pop_front();
          outw = w[1:0];
          if (w[2]) send_m = 1'b0;
        end
        if (psh) q.push_back({l, d});
      end
    end else if (psh) begin
      q.push_back({l, d});
    end
    sb.push_back('{pinw, send_m, und_m,
                   (q.size() < DEPTH)});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 2'b00, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #3;
    chk_en  = 1'b0;
    reset_n = 1'b0;
    enable  = 1'b0;
    valid   = 1'b0;
    #1;
    chk("rst_pin", {1'b0, pin_o}, 2'b00);
    chk("rst_ready", {1'b0, ready_o}, 2'b01);
    chk("rst_active", {1'b0, active_o}, 2'b00);
    chk("rst_underrun", {1'b0, und_o}, 2'b00);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    chk_en  = 1'b1;
  endtask

  // Monitor: one expected record per clock.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #2;
      if (chk_en && sb.size() > 0) begin
        x = sb.pop_front();
        chk("active", {1'b0, active_o}, {1'b0, x.act});
        chk("underrun", {1'b0, und_o}, {1'b0, x.und});
        chk("ready", {1'b0, ready_o}, {1'b0, x.rdy});
        chk("pin_b0", {1'b0, pin_o}, {1'b0, x.pin[0]});
        @(negedge clk);
        #2;
        if (chk_en)
          chk("pin_b1", {1'b0, pin_o}, {1'b0, x.pin[1]});
      end
    end
  end

  initial begin
    checks  = 0;
    errors  = 0;
    chk_en  = 1'b0;
    reset_n = 1'b1;
    enable  = 1'b0;
    valid   = 1'b0;
    data    = 2'b00;
    last    = 1'b0;
    model_reset();
    #1 reset_n = 1'b0;
    #1;
    chk("init_pin", {1'b0, pin_o}, 2'b00);
    chk("init_ready", {1'b0, ready_o}, 2'b01);
    chk("init_active", {1'b0, active_o}, 2'b00);
    chk("init_underrun", {1'b0, und_o}, 2'b00);
    @(negedge clk);
    reset_n = 1'b1;
    chk_en  = 1'b1;

    // basic three-word burst
    idle(2);
    step(1, 1, 2'b01, 0);
    step(1, 1, 2'b10, 0);
    step(1, 1, 2'b11, 1);
    idle(6);

    // fill while disabled, overflow attempt, drain
    step(0, 1, 2'b00, 0);
    step(0, 1, 2'b01, 0);
    step(0, 1, 2'b11, 0);
    step(0, 1, 2'b10, 1);
    step(0, 1, 2'b01, 1);
    step(0, 1, 2'b11, 0);
    for (int i = 0; i < 8; i++) step(1, 0, 2'b00, 0);

    // enable stall mid-burst
    step(1, 1, 2'b11, 0);
    step(1, 1, 2'b01, 0);
    step(1, 1, 2'b10, 1);
    step(1, 0, 2'b00, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 2'b00, 0);
    idle(6);

    // single-word burst
    step(1, 1, 2'b01, 1);
    idle(4);

    // push and pop together at level 1
    step(1, 1, 2'b01, 0);
    step(1, 1, 2'b11, 0);
    step(1, 0, 2'b00, 0);
    step(1, 1, 2'b00, 0);
    step(1, 1, 2'b10, 0);
    step(1, 1, 2'b01, 1);
    idle(5);

    // underrun: two words, no last
    step(1, 1, 2'b01, 0);
    step(1, 1, 2'b10, 0);
    idle(6);

    // reset in the middle of a burst
    do_reset();
    step(1, 1, 2'b11, 0);
    step(1, 1, 2'b01, 0);
    step(1, 1, 2'b00, 0);
    do_reset();
    idle(3);
    step(1, 1, 2'b01, 0);
    step(1, 1, 2'b10, 1);
    idle(4);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0),
           $urandom_range(0, 1),
           2'($urandom_range(0, 3)),
           ($urandom_range(0, 5) == 0));
    end
    idle(10);

    @(negedge clk);
    @(negedge clk);
    #3;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
